adc_capture_seq: RTL and testbench
==================================

# adc_capture_seq

Capture sequencer for the ADC front end. Owns generation of the ADC sample clock at a decade-selected rate (1×, 10×, … 10^7× half-period in `clk` cycles). Runs one capture burst per `start` command: divider restart, settle, N samples, then stop. Hands each sample downstream over a single-entry valid/ready register and flags overruns.

## Interface
Parameters:
- `DATA_W`, 12: ADC data width.
- `CNT_W`, 16: width of sample count.
- `SETTLE`, 4: sample events discarded after divider restart. 0 is legal.

Ports:
- `clk`  in  1  system clock. Single clock domain.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  begin burst; honoured only in IDLE.
- `abort`  in  1  terminate burst; honoured in any non-IDLE state.
- `cfg_div`  in  3  decade select k; half-period H = 10^k clk cycles. Latched at start.
- `num_samples`  in  CNT_W  samples to deliver. Latched at start.
- `adc_data`  in  DATA_W  ADC output bus.
- `adc_clk`  out  1  ADC sample clock, registered.
- `sample_data`  out  DATA_W  captured sample.
- `sample_valid`  out  1  sample_data valid.
- `sample_ready`  in  1  downstream accept.
- `busy`  out  1  state != IDLE.
- `done`  out  1  one-cycle pulse on normal completion.
- `overrun`  out  1  sticky; a sample was dropped. Cleared by an accepted start.

## Operation
- States: IDLE, ARM, SETTLE, CAPTURE, DONE.
- IDLE:
  - adc_clk=0, divider count=0.
  - start & !abort → ARM. Latches k and N, loads remaining=N and settle_cnt=SETTLE, clears overrun.
- ARM (1 cycle):
  - divider count cleared.
  - N=0 → DONE. SETTLE=0 → CAPTURE. Otherwise → SETTLE.
- Divider (SETTLE and CAPTURE only):
  - 24-bit count increments each cycle.
  - When count==H-1 (toggle event): count←0 and adc_clk inverts.
  - Table holds H-1 = 0, 9, 99, … 9_999_999.
- Capture event: a toggle event while adc_clk==1, i.e. the falling edge. Events occur every 2H cycles.
- SETTLE:
  - Each capture event decrements settle_cnt; adc_data is ignored.
  - The event that takes settle_cnt to 0 → CAPTURE.
- CAPTURE, on each capture event:
  - sample_data←adc_data and sample_valid←1.
  - remaining decrements. At 1 → DONE.
- Output register:
  - sample_valid & sample_ready clears valid.
  - On a capture event with valid & !ready, the new sample is dropped, overrun←1, and the event still counts toward N.
  - On a capture event with valid & ready, the new sample loads and valid stays 1, with no overrun.
- DONE (1 cycle): done=1, adc_clk=0 → IDLE.
- abort in ARM/SETTLE/CAPTURE/DONE → IDLE next cycle.
  - adc_clk←0, no done pulse.
  - A capture event in the abort cycle is discarded.
  - A pending sample_valid is kept until accepted.
- start while busy: ignored. start & abort in IDLE: abort wins, stay IDLE.
- cfg_div/num_samples changes while busy: no effect.

## Timing
- Reset values: adc_clk=0, sample_valid=0, sample_data=0, busy=0, done=0, overrun=0, state IDLE.
- Burst sequence, start sampled in IDLE at cycle T:
  - ARM at T+1, busy=1.
  - First SETTLE/CAPTURE cycle at T+2, count=0.
  - First rising toggle event at cycle T+1+H; adc_clk=1 from T+2+H.
- Capture event j (1-based, counting discarded ones) at cycle T+1+2jH.
- First delivered sample: event SETTLE+1, so sample_valid rises at T+2+2(SETTLE+1)H.
- Last delivered sample: event SETTLE+N.
  - DONE is the cycle after that event; IDLE the cycle after DONE.
- N=0: DONE at T+2, IDLE at T+3, adc_clk never toggles.
- Output latency: adc_data to sample_data is 1 cycle, registered on the capture-event edge.

## Test plan
- **Basic burst.** Reset, then k=0, N=3, SETTLE=4, ready=1, start at T → samples valid at T+12, T+14, T+16 carrying adc_data from T+11/13/15; done at T+16; busy low at T+17.
- **Decade rate.** k=2, N=2 → adc_clk half-period 100 cycles; first valid at T+1002; done exactly once.
- **Overrun.** k=0, N=4, ready=0 → only first sample held; overrun=1; done still fires. Next start clears overrun.
- **Abort mid-CAPTURE.** Abort after 1 sample → IDLE next cycle, adc_clk=0, no done, pending sample retained until ready.
- **Zero count and config edges.**
  - N=0 → done at T+2, no adc_clk edge.
  - start during busy ignored.
  - start+abort in IDLE stays IDLE.
- **Reset mid-burst.** Assert rst during CAPTURE → all outputs return to reset values next cycle; new start behaves as in the basic burst case.

Source files
------------

// File: rtl/adc_capture_seq.sv
// rtl/adc_capture_seq.sv - ADC capture burst sequencer with decade sample-clock divider
// One burst per start: divider restart, settle events discarded, N samples handed downstream.
module adc_capture_seq #(
    parameter int DATA_W = 12,
    parameter int CNT_W  = 16,
    parameter int SETTLE = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [2:0]        cfg_div,
    input  logic [CNT_W-1:0]  num_samples,
    input  logic [DATA_W-1:0] adc_data,
    output logic              adc_clk,
    output logic [DATA_W-1:0] sample_data,
    output logic              sample_valid,
    input  logic              sample_ready,
    output logic              busy,
    output logic              done,
    output logic              overrun
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_SETTLE,
        S_CAPTURE,
        S_DONE
    } state_t;

    state_t              state_q;
    logic [2:0]          k_q;
    logic [CNT_W-1:0]    remaining_q;
    logic [15:0]         settle_q;
    logic [23:0]         div_q;
    logic [23:0]         div_d;
    logic                adc_clk_q;
    logic [DATA_W-1:0]   data_q;
    logic                valid_q;
    logic                done_q;
    logic                overrun_q;

    logic                running;
    logic                toggle;
    logic                cap_evt;
    logic [23:0]         half_m1;

    function automatic logic [23:0] decade_m1(input logic [2:0] k);
        case (k)
            3'd0:    decade_m1 = 24'd0;
            3'd1:    decade_m1 = 24'd9;
            3'd2:    decade_m1 = 24'd99;
            3'd3:    decade_m1 = 24'd999;
            3'd4:    decade_m1 = 24'd9999;
            3'd5:    decade_m1 = 24'd99999;
            3'd6:    decade_m1 = 24'd999999;
            default: decade_m1 = 24'd9999999;
        endcase
    endfunction

    assign half_m1 = decade_m1(k_q);
    assign running = (state_q == S_SETTLE) || (state_q == S_CAPTURE);
    assign toggle  = running && (div_q == half_m1);
    // Samples are taken on the falling edge of the ADC clock.
    assign cap_evt = toggle && adc_clk_q;
    assign div_d   = toggle ? 24'd0 : div_q + 24'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            k_q         <= 3'd0;
            remaining_q <= '0;
            settle_q    <= 16'd0;
            div_q       <= 24'd0;
            adc_clk_q   <= 1'b0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            done_q      <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (valid_q && sample_ready) begin
                valid_q <= 1'b0;
            end
            case (state_q)
                S_IDLE: begin
                    adc_clk_q <= 1'b0;
                    div_q     <= 24'd0;
                    if (start && !abort) begin
                        state_q     <= S_ARM;
                        k_q         <= cfg_div;
                        remaining_q <= num_samples;
                        settle_q    <= 16'(SETTLE);
                        overrun_q   <= 1'b0;
                    end
                end
                S_ARM: begin
                    div_q     <= 24'd0;
                    adc_clk_q <= 1'b0;
                    if (abort) begin
                        state_q <= S_IDLE;
                    end else if (remaining_q == '0) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                    end else if (settle_q == 16'd0) begin
                        state_q <= S_CAPTURE;
                    end else begin
                        state_q <= S_SETTLE;
                    end
                end
                S_SETTLE, S_CAPTURE: begin
                    if (abort) begin
                        state_q   <= S_IDLE;
                        adc_clk_q <= 1'b0;
                        div_q     <= 24'd0;
                    end else begin
                        div_q <= div_d;
                        if (toggle) begin
                            adc_clk_q <= ~adc_clk_q;
                        end
                        if (cap_evt && state_q == S_SETTLE) begin
                            settle_q <= settle_q - 16'd1;
                            if (settle_q == 16'd1) begin
                                state_q <= S_CAPTURE;
                            end
                        end
                        if (cap_evt && state_q == S_CAPTURE) begin
                            // A held, unaccepted sample wins; the new one is dropped but still counts.
                            if (!valid_q || sample_ready) begin
                                data_q  <= adc_data;
                                valid_q <= 1'b1;
                            end else begin
                                overrun_q <= 1'b1;
                            end
                            remaining_q <= remaining_q - CNT_W'(1);
                            if (remaining_q == CNT_W'(1)) begin
                                state_q   <= S_DONE;
                                done_q    <= 1'b1;
                                adc_clk_q <= 1'b0;
                            end
                        end
                    end
                end
                S_DONE: begin
                    adc_clk_q <= 1'b0;
                    div_q     <= 24'd0;
                    state_q   <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign adc_clk      = adc_clk_q;
    assign sample_data  = data_q;
    assign sample_valid = valid_q;
    assign busy         = (state_q != S_IDLE);
    assign done         = done_q;
    assign overrun      = overrun_q;

endmodule

// File: tb/tb_adc_capture_seq.sv
// tb/tb_adc_capture_seq.sv - directed self-checking bench for adc_capture_seq
module tb_adc_capture_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [2:0]  cfg_div = 3'd0;
    logic [15:0] num_samples = 16'd0;
    logic [11:0] adc_data = 12'd0;
    logic        adc_clk;
    logic [11:0] sample_data;
    logic        sample_valid;
    logic        sample_ready = 1'b0;
    logic        busy;
    logic        done;
    logic        overrun;

    int compared = 0;
    int mismatched = 0;
    int cyc = 0;

    adc_capture_seq #(.DATA_W(12), .CNT_W(16), .SETTLE(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .abort        (abort),
        .cfg_div      (cfg_div),
        .num_samples  (num_samples),
        .adc_data     (adc_data),
        .adc_clk      (adc_clk),
        .sample_data  (sample_data),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .busy         (busy),
        .done         (done),
        .overrun      (overrun)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] data_at(input int c);
        data_at = 12'(c * 37 + 5);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        adc_data = data_at(cyc);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_adc_clk"}, 32'(adc_clk), 32'd0);
        chk({tag, "_valid"}, 32'(sample_valid), 32'd0);
        chk({tag, "_data"}, 32'(sample_data), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_overrun"}, 32'(overrun), 32'd0);
    endtask

    task automatic pulse_start(input logic [2:0] k, input logic [15:0] n);
        cfg_div = k;
        num_samples = n;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic run_basic(input string tag);
        int t0;
        t0 = cyc;
        sample_ready = 1'b1;
        pulse_start(3'd0, 16'd3);
        for (int c = 1; c <= 17; c++) begin
            chk({tag, "_valid"}, 32'(sample_valid), 32'(c == 12 || c == 14 || c == 16));
            chk({tag, "_busy"}, 32'(busy), 32'(c <= 16));
            chk({tag, "_done"}, 32'(done), 32'(c == 16));
            chk({tag, "_adc_clk"}, 32'(adc_clk), 32'(c >= 3 && c <= 15 && (c % 2) == 1));
            if (c == 12 || c == 14 || c == 16)
                chk({tag, "_data"}, 32'(sample_data), 32'(data_at(t0 + c - 1)));
            tick();
        end
    endtask

    initial begin
        int t0;
        int first_valid;
        int first_clk;
        int done_cnt;
        int done_at;
        logic [11:0] fv_data;

        tick();
        tick();
        check_reset_vals("reset");
        rst = 1'b0;
        tick();

        run_basic("basic");

        // Decade rate, k=2 -> H=100
        t0 = cyc;
        first_valid = -1;
        first_clk = -1;
        done_cnt = 0;
        done_at = -1;
        fv_data = 12'd0;
        sample_ready = 1'b1;
        pulse_start(3'd2, 16'd2);
        for (int c = 1; c <= 1210; c++) begin
            if (sample_valid && first_valid < 0) begin
                first_valid = c;
                fv_data = sample_data;
            end
            if (adc_clk && first_clk < 0) first_clk = c;
            if (done) begin
                done_cnt++;
                done_at = c;
            end
            tick();
        end
        chk("dec_first_clk", 32'(first_clk), 32'd102);
        chk("dec_first_valid", 32'(first_valid), 32'd1002);
        chk("dec_first_data", 32'(fv_data), 32'(data_at(t0 + 1001)));
        chk("dec_done_cnt", 32'(done_cnt), 32'd1);
        chk("dec_done_at", 32'(done_at), 32'd1202);
        chk("dec_busy_end", 32'(busy), 32'd0);

        // Overrun with ready held low
        t0 = cyc;
        done_at = -1;
        sample_ready = 1'b0;
        pulse_start(3'd0, 16'd4);
        for (int c = 1; c <= 19; c++) begin
            if (done) done_at = c;
            if (c == 13) chk("ovr_pre", 32'(overrun), 32'd0);
            if (c == 14) chk("ovr_set", 32'(overrun), 32'd1);
            tick();
        end
        chk("ovr_done_at", 32'(done_at), 32'd18);
        chk("ovr_valid", 32'(sample_valid), 32'd1);
        chk("ovr_data", 32'(sample_data), 32'(data_at(t0 + 11)));
        chk("ovr_sticky", 32'(overrun), 32'd1);
        chk("ovr_busy", 32'(busy), 32'd0);
        sample_ready = 1'b1;
        tick();
        sample_ready = 1'b0;
        chk("ovr_accept", 32'(sample_valid), 32'd0);
        chk("ovr_kept", 32'(overrun), 32'd1);
        pulse_start(3'd0, 16'd1);
        chk("ovr_cleared", 32'(overrun), 32'd0);
        chk("ovr_restart_busy", 32'(busy), 32'd1);
        done_cnt = 0;
        for (int c = 2; c <= 14; c++) begin
            if (done) done_cnt++;
            tick();
        end
        chk("ovr_restart_done", 32'(done_cnt), 32'd1);
        chk("ovr_restart_valid", 32'(sample_valid), 32'd1);
        sample_ready = 1'b1;
        tick();
        sample_ready = 1'b0;

        // Abort mid-CAPTURE on a capture-event cycle
        t0 = cyc;
        pulse_start(3'd0, 16'd3);
        for (int c = 2; c <= 13; c++) tick();
        chk("abt_pre_clk", 32'(adc_clk), 32'd1);
        chk("abt_pre_valid", 32'(sample_valid), 32'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abt_busy", 32'(busy), 32'd0);
        chk("abt_adc_clk", 32'(adc_clk), 32'd0);
        chk("abt_valid", 32'(sample_valid), 32'd1);
        chk("abt_data", 32'(sample_data), 32'(data_at(t0 + 11)));
        chk("abt_overrun", 32'(overrun), 32'd0);
        done_cnt = 0;
        first_clk = 0;
        for (int c = 0; c < 5; c++) begin
            if (done) done_cnt++;
            if (adc_clk) first_clk++;
            tick();
        end
        chk("abt_no_done", 32'(done_cnt), 32'd0);
        chk("abt_clk_idle", 32'(first_clk), 32'd0);
        chk("abt_held", 32'(sample_valid), 32'd1);
        sample_ready = 1'b1;
        tick();
        chk("abt_accept", 32'(sample_valid), 32'd0);

        // N=0
        pulse_start(3'd0, 16'd0);
        for (int c = 1; c <= 4; c++) begin
            chk("n0_busy", 32'(busy), 32'(c <= 2));
            chk("n0_done", 32'(done), 32'(c == 2));
            chk("n0_adc_clk", 32'(adc_clk), 32'd0);
            tick();
        end

        // start while busy ignored, config changes ignored
        t0 = cyc;
        pulse_start(3'd0, 16'd1);
        cfg_div = 3'd3;
        num_samples = 16'd5;
        for (int c = 1; c <= 14; c++) begin
            start = (c == 5);
            chk("bsy_busy", 32'(busy), 32'(c <= 12));
            chk("bsy_done", 32'(done), 32'(c == 12));
            chk("bsy_valid", 32'(sample_valid), 32'(c == 12));
            if (c == 12) chk("bsy_data", 32'(sample_data), 32'(data_at(t0 + 11)));
            tick();
        end
        start = 1'b0;

        // start and abort together in IDLE
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        chk("sa_busy0", 32'(busy), 32'd0);
        tick();
        chk("sa_busy1", 32'(busy), 32'd0);
        chk("sa_done", 32'(done), 32'd0);

        // Reset mid-burst
        sample_ready = 1'b0;
        pulse_start(3'd0, 16'd3);
        for (int c = 2; c <= 13; c++) tick();
        chk("rmb_adc_clk", 32'(adc_clk), 32'd1);
        chk("rmb_busy", 32'(busy), 32'd1);
        chk("rmb_valid", 32'(sample_valid), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_reset_vals("rmb");
        run_basic("post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
